if_stage: RTL and testbench

- Instruction-fetch stage that feeds the decode/execute datapath.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned instruction into the IF/ID pipeline register together with its PC and PC+4.
- Supports pipeline stall (hold) and control-flow redirect (branch/jal/jalr target with flush of the IF/ID slot).

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 64 ++++++
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared constants and types for the fetch/decode pipeline.
//           NOP_INSTR : canonical "addi x0,x0,0" used to fill flushed slots
//           PC_INC    : byte increment between sequential instructions
//           fetch_action_e : the single action the fetch stage takes per edge
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef enum logic [1:0] {
    FA_REDIRECT = 2'd0,
    FA_STALL    = 2'd1,
    FA_ADVANCE  = 2'd2
  } fetch_action_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Purpose : Generic pipeline register carrying {instr, pc, pc+4, valid}.
//           Flush loads a NOP bubble and clears valid; hold keeps contents.
//           Flush has priority over hold. Also reused between ID and EX.
// Ports   : clk, reset (async, active-low)
//           i_hold, i_flush        : control
//           i_instr/i_pc/i_pc_plus4: next slot contents (valid is set on load)
//           o_instr/o_pc/o_pc_plus4/o_valid : registered slot
// Rev     : 1.0  initial release
// ============================================================================
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic [INS_W-1:0] i_instr,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [PC_W-1:0]  i_pc_plus4,
  output logic [INS_W-1:0] o_instr,
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_pc_plus4,
  output logic             o_valid
);

  localparam logic [INS_W-1:0] C_NOP = INS_W'(NOP_INSTR);

  logic [INS_W-1:0] r_instr;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_pc_plus4;
  logic             r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= C_NOP;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= C_NOP;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Purpose : Instruction-fetch stage. Owns the PC, drives the instruction
//           memory address and captures the fetched instruction into IF/ID.
//           Per edge, exactly one action: redirect > stall > advance.
// Ports   : clk, reset (async, active-low)
//           stall_i, redirect_i, redirect_pc_i : pipeline control
//           imem_rdata_i / imem_addr_o         : combinational imem port
//           id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o : IF/ID slot
//           fetch_cnt_o, flush_cnt_o           : performance counters
// Config  : IF_PERF_CNT_EN - when defined, fetch/flush counters are built;
//           otherwise both counter ports are tied to zero.
// Rev     : 1.0  initial release
// ============================================================================
module if_stage
  import riscv_pkg::*;
#(
  parameter int              PC_W   = 9,
  parameter int              INS_W  = 32,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  input  logic [INS_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic [INS_W-1:0] id_instr_o,
  output logic [PC_W-1:0]  id_pc_o,
  output logic [PC_W-1:0]  id_pc_plus4_o,
  output logic             id_valid_o,
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      flush_cnt_o
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_redirect_tgt;
  logic [PC_W-1:0] w_pc_next;
  fetch_action_e   w_action;

  // Target low bits are dropped: instructions are always word aligned.
  assign w_redirect_tgt = {redirect_pc_i[PC_W-1:2], 2'b00};
  // Sink for the ignored alignment bits.
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^redirect_pc_i[1:0];

  // Wraps naturally modulo 2^PC_W.
  assign w_pc_plus4 = r_pc + PC_W'(PC_INC);

  always_comb begin
    w_action = FA_ADVANCE;
    if (redirect_i) begin
      w_action = FA_REDIRECT;
    end else if (stall_i) begin
      w_action = FA_STALL;
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_action)
      FA_REDIRECT: w_pc_next = w_redirect_tgt;
      FA_STALL:    w_pc_next = r_pc;
      FA_ADVANCE:  w_pc_next = w_pc_plus4;
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RST_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign imem_addr_o = r_pc;

  if_id_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .i_hold     (w_action == FA_STALL),
    .i_flush    (w_action == FA_REDIRECT),
    .i_instr    (imem_rdata_i),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (id_instr_o),
    .o_pc       (id_pc_o),
    .o_pc_plus4 (id_pc_plus4_o),
    .o_valid    (id_valid_o)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_action == FA_ADVANCE)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_action == FA_REDIRECT) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign fetch_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Purpose : Self-checking bench for if_stage. A reference model of the PC and
//           IF/ID slot pushes the expected slot after each edge into a
//           scoreboard queue; each test pops and compares against the DUT.
// Config  : IF_PERF_CNT_EN selects expected counter behaviour.
// Rev     : 1.0  initial release
// ============================================================================
module tb_if_stage;
  import riscv_pkg::*;

  localparam int PC_W = 9;

  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic            valid;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall_i = 1'b0;
  logic            redirect_i = 1'b0;
  logic [PC_W-1:0] redirect_pc_i = '0;
  logic [31:0]     imem_rdata_i;
  logic [PC_W-1:0] imem_addr_o;
  logic [31:0]     id_instr_o;
  logic [PC_W-1:0] id_pc_o;
  logic [PC_W-1:0] id_pc_plus4_o;
  logic            id_valid_o;
  logic [31:0]     fetch_cnt_o;
  logic [31:0]     flush_cnt_o;

  if_stage #(.PC_W(PC_W), .INS_W(32), .RST_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_addr_o   (imem_addr_o),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_valid_o    (id_valid_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, then an address tag.
  function automatic logic [31:0] imem_f(input logic [PC_W-1:0] a);
    if (a == 9'd0) return 32'h00A0_0093;
    if (a == 9'd4) return 32'h0010_0113;
    return 32'hA500_0000 | {23'd0, a};
  endfunction

  assign imem_rdata_i = imem_f(imem_addr_o);

  // Reference model state
  logic [PC_W-1:0] m_pc;
  exp_t            m_slot;
  int unsigned     m_fetch, m_flush;
  int              cov [3];
  exp_t            sb [$];
  exp_t            e;
  int              n_chk = 0;
  int              n_pass = 0;

  task automatic model_reset();
    m_pc    = '0;
    m_slot  = '{addr: '0, instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
    m_fetch = 0;
    m_flush = 0;
    sb.delete();
  endtask

  // Drive one edge with the given controls, advance the model, push expected.
  task automatic tick(input logic st, input logic rd, input logic [PC_W-1:0] tgt);
    fetch_action_e act;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    act = rd ? FA_REDIRECT : (st ? FA_STALL : FA_ADVANCE);
    cov[act]++;
    case (act)
      FA_REDIRECT: begin
        m_slot = '{addr: '0, instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
        m_pc   = {tgt[PC_W-1:2], 2'b00};
        m_flush++;
      end
      FA_ADVANCE: begin
        m_slot = '{addr: '0, instr: imem_f(m_pc), pc: m_pc, pc4: m_pc + 9'd4, valid: 1'b1};
        m_pc   = m_pc + 9'd4;
        m_fetch++;
      end
      default: ;
    endcase
    m_slot.addr = m_pc;
    sb.push_back(m_slot);
    @(posedge clk);
    #1;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
  endtask

  function automatic logic [31:0] exp_fetch_cnt();
`ifdef IF_PERF_CNT_EN
    return m_fetch;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush_cnt();
`ifdef IF_PERF_CNT_EN
    return m_flush;
`else
    return 32'd0;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !==
        {9'd0, 32'h0000_0013, 9'd0, 9'd0, 1'b0}) begin
      $display("FAIL reset_state got addr=%h instr=%h pc=%h pc4=%h v=%b",
               imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o);
    end else n_pass++;
    n_chk++;
    if ({fetch_cnt_o, flush_cnt_o} !== 64'd0) begin
      $display("FAIL reset_cnt got fetch=%0d flush=%0d want 0/0", fetch_cnt_o, flush_cnt_o);
    end else n_pass++;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, '0);
      e = sb.pop_front();
      n_chk++;
      if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e) begin
        $display("FAIL free_run[%0d] got addr=%h instr=%h pc=%h pc4=%h v=%b want addr=%h instr=%h pc=%h pc4=%h v=%b",
                 i, imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o,
                 e.addr, e.instr, e.pc, e.pc4, e.valid);
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, '0);
      e = sb.pop_front();
      n_chk++;
      if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !==
          {9'd8, 32'h0010_0113, 9'd4, 9'd8, 1'b1} || e.addr !== 9'd8) begin
        $display("FAIL stall_hold[%0d] got addr=%h instr=%h pc=%h pc4=%h v=%b want addr=008 instr=00100113 pc=004 pc4=008 v=1",
                 i, imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o);
      end else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, '0);
      e = sb.pop_front();
      n_chk++;
      if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e) begin
        $display("FAIL stall_release[%0d] got addr=%h instr=%h pc=%h v=%b want addr=%h instr=%h pc=%h v=%b",
                 i, imem_addr_o, id_instr_o, id_pc_o, id_valid_o, e.addr, e.instr, e.pc, e.valid);
      end else n_pass++;
    end
  endtask

  task automatic test_redirect();
    // PC is 16 here; misaligned target must be word-aligned.
    tick(1'b0, 1'b1, 9'h043);
    e = sb.pop_front();
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !==
        {9'h040, 32'h0000_0013, 9'd0, 9'd0, 1'b0} || e.addr !== 9'h040) begin
      $display("FAIL redirect_flush got addr=%h instr=%h pc=%h pc4=%h v=%b want addr=040 nop bubble",
               imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o);
    end else n_pass++;
    tick(1'b0, 1'b0, '0);
    e = sb.pop_front();
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e || id_pc_o !== 9'h040) begin
      $display("FAIL redirect_target got addr=%h instr=%h pc=%h v=%b want addr=%h instr=%h pc=%h v=%b",
               imem_addr_o, id_instr_o, id_pc_o, id_valid_o, e.addr, e.instr, e.pc, e.valid);
    end else n_pass++;
  endtask

  task automatic test_redirect_over_stall();
    logic [31:0] flush_before;
    tick(1'b0, 1'b1, 9'h014);
    e = sb.pop_front();
    flush_before = flush_cnt_o;
    tick(1'b1, 1'b1, 9'h100);
    e = sb.pop_front();
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e || imem_addr_o !== 9'h100) begin
      $display("FAIL redirect_stall got addr=%h instr=%h v=%b want addr=100 instr=00000013 v=0",
               imem_addr_o, id_instr_o, id_valid_o);
    end else n_pass++;
    n_chk++;
`ifdef IF_PERF_CNT_EN
    if (flush_cnt_o !== flush_before + 32'd1) begin
`else
    if (flush_cnt_o !== 32'd0 || flush_before !== 32'd0) begin
`endif
      $display("FAIL flush_cnt_step got %0d (before %0d)", flush_cnt_o, flush_before);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 9'h1F8);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, '0);
      e = sb.pop_front();
      n_chk++;
      if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e) begin
        $display("FAIL wrap[%0d] got addr=%h pc=%h pc4=%h v=%b want addr=%h pc=%h pc4=%h v=%b",
                 i, imem_addr_o, id_pc_o, id_pc_plus4_o, id_valid_o, e.addr, e.pc, e.pc4, e.valid);
      end else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (id_pc_o !== 9'h1FC || id_pc_plus4_o !== 9'd0 || imem_addr_o !== 9'd0) begin
          $display("FAIL wrap_point got pc=%h pc4=%h addr=%h want 1fc/000/000",
                   id_pc_o, id_pc_plus4_o, imem_addr_o);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_counters();
    n_chk++;
    if (fetch_cnt_o !== exp_fetch_cnt() || flush_cnt_o !== exp_flush_cnt()) begin
      $display("FAIL counters got fetch=%0d flush=%0d want fetch=%0d flush=%0d",
               fetch_cnt_o, flush_cnt_o, exp_fetch_cnt(), exp_flush_cnt());
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 9'h028);
    e = sb.pop_front();
    tick(1'b0, 1'b0, '0);
    e = sb.pop_front();
    tick(1'b0, 1'b0, '0);
    e = sb.pop_front();
    n_chk++;
    if (imem_addr_o !== 9'h030 || id_valid_o !== 1'b1) begin
      $display("FAIL pre_reset got addr=%h v=%b want 030/1", imem_addr_o, id_valid_o);
    end else n_pass++;
    // Mid-cycle reset pulse, well away from any rising edge.
    reset = 1'b0;
    #2;
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o, fetch_cnt_o, flush_cnt_o} !==
        {9'd0, 32'h0000_0013, 9'd0, 9'd0, 1'b0, 64'd0}) begin
      $display("FAIL async_reset got addr=%h instr=%h pc=%h pc4=%h v=%b fc=%0d flc=%0d want all reset values",
               imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o, fetch_cnt_o, flush_cnt_o);
    end else n_pass++;
    #3;
    reset = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, '0);
    e = sb.pop_front();
    n_chk++;
    if ({imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, id_valid_o} !== e ||
        id_instr_o !== 32'h00A0_0093) begin
      $display("FAIL restart got addr=%h instr=%h pc=%h v=%b want addr=%h instr=%h pc=%h v=%b",
               imem_addr_o, id_instr_o, id_pc_o, id_valid_o, e.addr, e.instr, e.pc, e.valid);
    end else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cov = '{0, 0, 0};
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_counters();
    test_redirect_over_stall();
    test_wrap();
    test_counters();
    test_async_reset();
    test_counters();
    $display("coverage: redirect=%0d stall=%0d advance=%0d",
             cov[FA_REDIRECT], cov[FA_STALL], cov[FA_ADVANCE]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_if_stage
`default_nettype wire
